// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl
// Time-shares one combinational 32-bit ALU between two requesters.
// The block arbitrates between the two request ports and registers the
// winner's operands onto the ALU inputs. It then captures the ALU result
// and zero flag and returns them on that requester's response channel.
//
// Handshake rules (valid/ready on both channels):
//   A request transfers on a cycle where req_valid[i] & req_ready[i].
//   A response transfers on an edge where resp_valid[i] & resp_ready[i].
//   A source holds valid and its payload stable until the transfer.
//   Ready may be asserted without valid.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   req_valid/req_ready [1:0]   per-requester request handshake
//   req{0,1}_a/_b/_op           operands and 3-bit opcode
//   resp_valid/resp_ready [1:0] per-requester response handshake
//   resp{0,1}_data/_zero        captured ALU result and zero flag
//   alu_a/alu_b/alu_op          registered operands driven to the ALU
//   alu_out/alu_zero            ALU result inputs
//   busy                        high while an operation is executing
//
// Build option: define ALU_SHARE_STRICT_PRIO_EN for fixed priority.
// Requester 0 then wins every tie. The default build uses round-robin.
module alu_share_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req0_op,
  input  logic [2:0]  req1_op,
  output logic [1:0]  resp_valid,
  input  logic [1:0]  resp_ready,
  output logic [31:0] resp0_data,
  output logic [31:0] resp1_data,
  output logic        resp0_zero,
  output logic        resp1_zero,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_out,
  input  logic        alu_zero,
  output logic        busy
);

  typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

  state_t      state_q;
  logic        busy_q;
  logic        owner_q;
  logic        last_q;
  logic [31:0] alu_a_q, alu_b_q;
  logic [2:0]  alu_op_q;
  logic [1:0]  resp_valid_q, resp_valid_d;
  logic [31:0] resp0_data_q, resp1_data_q;
  logic        resp0_zero_q, resp1_zero_q;

  logic [1:0]  eligible;
  logic        gnt_any;
  logic        win;

  // A requester whose previous result is still pending is not eligible.
  // resp_ready is deliberately kept out of this path.
  assign eligible = req_valid & ~resp_valid_q;
  assign gnt_any  = !rst && (state_q == IDLE) && (eligible != 2'b00);

  always_comb begin
    win = 1'b0;
    if (eligible == 2'b10) begin
      win = 1'b1;
    end else if (eligible == 2'b11) begin
`ifdef ALU_SHARE_STRICT_PRIO_EN
      win = 1'b0;
`else
      // Round-robin: the requester not granted last time wins.
      win = ~last_q;
`endif
    end
  end

  always_comb begin
    req_ready = 2'b00;
    if (gnt_any) begin
      req_ready = win ? 2'b10 : 2'b01;
    end
  end

  // The set in EXEC takes precedence. The owner's bit is always low
  // during EXEC, so the set and the clear never collide on one bit.
  always_comb begin
    resp_valid_d = resp_valid_q & ~resp_ready;
    if (state_q == EXEC) begin
      resp_valid_d[owner_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      owner_q      <= 1'b0;
      last_q       <= 1'b1;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      resp_valid_q <= 2'b00;
      resp0_data_q <= '0;
      resp1_data_q <= '0;
      resp0_zero_q <= 1'b0;
      resp1_zero_q <= 1'b0;
    end else begin
      resp_valid_q <= resp_valid_d;
      case (state_q)
        IDLE: begin
          if (gnt_any) begin
            alu_a_q  <= win ? req1_a  : req0_a;
            alu_b_q  <= win ? req1_b  : req0_b;
            alu_op_q <= win ? req1_op : req0_op;
            owner_q  <= win;
            last_q   <= win;
            state_q  <= EXEC;
            busy_q   <= 1'b1;
          end
        end
        EXEC: begin
          if (owner_q) begin
            resp1_data_q <= alu_out;
            resp1_zero_q <= alu_zero;
          end else begin
            resp0_data_q <= alu_out;
            resp0_zero_q <= alu_zero;
          end
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign resp_valid = resp_valid_q;
  assign resp0_data = resp0_data_q;
  assign resp1_data = resp1_data_q;
  assign resp0_zero = resp0_zero_q;
  assign resp1_zero = resp1_zero_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Testbench for alu_share_ctrl. A behavioural ALU is attached to the
// alu_* ports. Directed scenarios are checked against hand-computed
// values.
module tb_alu_share_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, resp_valid, resp_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic [31:0] resp0_data, resp1_data;
  logic        resp0_zero, resp1_zero;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [2:0]  alu_op;
  logic        alu_zero, busy;

  int n_cmp = 0;
  int n_err = 0;

  // clock / reset
  always #5 clk = ~clk;

  alu_share_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_op(req0_op), .req1_op(req1_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp0_data(resp0_data), .resp1_data(resp1_data),
    .resp0_zero(resp0_zero), .resp1_zero(resp1_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_zero(alu_zero), .busy(busy)
  );

  // behavioural ALU
  always_comb begin
    case (alu_op)
      3'b000:  alu_out = alu_a + alu_b;
      3'b001:  alu_out = alu_a - alu_b;
      3'b010:  alu_out = alu_a & alu_b;
      3'b011:  alu_out = alu_a | alu_b;
      3'b101:  alu_out = (alu_a < alu_b) ? 32'd1 : 32'd0;
      3'b110:  alu_out = alu_b << alu_a[4:0];
      default: alu_out = 32'd0;
    endcase
  end
  assign alu_zero = (alu_out == 32'd0);

  task automatic test_reset;
    rst = 1'b1; req_valid = 2'b11; resp_ready = 2'b00;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0; req0_op = '0; req1_op = '0;
    #2;
    n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL rst_req_ready: got %b want 00", req_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (resp_valid !== 2'b00) begin n_err++; $display("FAIL rst_resp_valid: got %b want 00", resp_valid); end
    n_cmp++; if ({alu_a, alu_b, alu_op} !== 67'd0) begin n_err++; $display("FAIL rst_alu: got %h/%h/%h want 0", alu_a, alu_b, alu_op); end
    n_cmp++; if ({resp0_data, resp1_data, resp0_zero, resp1_zero} !== 66'd0) begin n_err++; $display("FAIL rst_resp_data: got %h/%h/%b/%b want 0", resp0_data, resp1_data, resp0_zero, resp1_zero); end
    @(negedge clk);
    rst = 1'b0; req_valid = 2'b00;
  endtask

  task automatic test_single_add;
    req_valid = 2'b01; req0_op = 3'b000; req0_a = 32'd5; req0_b = 32'd3; #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL add_ready: got %b want 01", req_ready); end
    @(negedge clk); req_valid = 2'b00; #1;
    n_cmp++; if (alu_op !== 3'b000 || alu_a !== 32'd5 || alu_b !== 32'd3) begin n_err++; $display("FAIL add_alu_in: got %h/%h/%h want 0/5/3", alu_op, alu_a, alu_b); end
    n_cmp++; if (busy !== 1'b1 || req_ready !== 2'b00 || resp_valid !== 2'b00) begin n_err++; $display("FAIL add_exec: got busy %b rdy %b rv %b want 1/00/00", busy, req_ready, resp_valid); end
    @(negedge clk); #1;
    n_cmp++; if (resp_valid !== 2'b01 || resp0_data !== 32'd8 || resp0_zero !== 1'b0) begin n_err++; $display("FAIL add_resp: got %b/%0d/%b want 01/8/0", resp_valid, resp0_data, resp0_zero); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL add_busy_low: got %b want 0", busy); end
    resp_ready = 2'b01;
    @(negedge clk); #1;
    n_cmp++; if (resp_valid !== 2'b00 || resp0_data !== 32'd8) begin n_err++; $display("FAIL add_consume: got %b/%0d want 00/8", resp_valid, resp0_data); end
    resp_ready = 2'b00;
  endtask

  task automatic test_sub_shift;
    logic [2:0]  ops [2];
    logic [31:0] as [2], bs [2], exp_d [2];
    logic        exp_z [2];
    ops[0] = 3'b001; as[0] = 32'd7; bs[0] = 32'd7; exp_d[0] = 32'd0;  exp_z[0] = 1'b1;
    ops[1] = 3'b110; as[1] = 32'd4; bs[1] = 32'd1; exp_d[1] = 32'd16; exp_z[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid = 2'b10; req1_op = ops[i]; req1_a = as[i]; req1_b = bs[i]; #1;
      n_cmp++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL r1_ready[%0d]: got %b want 10", i, req_ready); end
      @(negedge clk); req_valid = 2'b00; #1;
      n_cmp++; if (alu_op !== ops[i] || busy !== 1'b1) begin n_err++; $display("FAIL r1_exec[%0d]: got op %b busy %b want %b/1", i, alu_op, busy, ops[i]); end
      @(negedge clk); #1;
      n_cmp++; if (resp_valid !== 2'b10 || resp1_data !== exp_d[i] || resp1_zero !== exp_z[i]) begin n_err++; $display("FAIL r1_resp[%0d]: got %b/%0d/%b want 10/%0d/%b", i, resp_valid, resp1_data, resp1_zero, exp_d[i], exp_z[i]); end
      resp_ready = 2'b10;
      @(negedge clk); resp_ready = 2'b00;
    end
  endtask

  task automatic test_round_robin;
    logic w;
    req0_op = 3'b000; req0_a = 32'd10;     req0_b = 32'd20;
    req1_op = 3'b010; req1_a = 32'hF0F0;   req1_b = 32'hFF00;
    req_valid = 2'b11; resp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      w = k[0];
      #1;
      n_cmp++; if (req_ready !== (w ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL rr_grant[%0d]: got %b want %b", k, req_ready, w ? 2'b10 : 2'b01); end
      @(negedge clk); #1;
      n_cmp++; if (busy !== 1'b1 || alu_op !== (w ? 3'b010 : 3'b000)) begin n_err++; $display("FAIL rr_exec[%0d]: got busy %b op %b", k, busy, alu_op); end
      @(negedge clk); #1;
      if (w) begin
        n_cmp++; if (resp_valid[1] !== 1'b1 || resp1_data !== 32'hF000) begin n_err++; $display("FAIL rr_resp1[%0d]: got %b/%h want 1/f000", k, resp_valid[1], resp1_data); end
      end else begin
        n_cmp++; if (resp_valid[0] !== 1'b1 || resp0_data !== 32'd30) begin n_err++; $display("FAIL rr_resp0[%0d]: got %b/%0d want 1/30", k, resp_valid[0], resp0_data); end
      end
      if (k == 3) req_valid = 2'b00;
    end
    @(negedge clk); #1;
    n_cmp++; if (resp_valid !== 2'b00) begin n_err++; $display("FAIL rr_drain: got %b want 00", resp_valid); end
    resp_ready = 2'b00;
  endtask

  task automatic test_backpressure;
    resp_ready = 2'b00;
    req_valid = 2'b01; req0_op = 3'b011; req0_a = 32'd1; req0_b = 32'd2; #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL bp_first: got %b want 01", req_ready); end
    @(negedge clk);
    req0_op = 3'b000; req0_a = 32'd100; req0_b = 32'd1;
    req1_op = 3'b001; req1_a = 32'd9;   req1_b = 32'd4;
    req_valid = 2'b11; #1;
    @(negedge clk); #1;
    n_cmp++; if (resp_valid !== 2'b01 || resp0_data !== 32'd3 || req_ready !== 2'b10) begin n_err++; $display("FAIL bp_r1_served: got rv %b d %0d rdy %b want 01/3/10", resp_valid, resp0_data, req_ready); end
    @(negedge clk); #1;
    n_cmp++; if (alu_op !== 3'b001 || alu_a !== 32'd9 || req_ready !== 2'b00) begin n_err++; $display("FAIL bp_exec1: got op %b a %0d rdy %b want 001/9/00", alu_op, alu_a, req_ready); end
    @(negedge clk); #1;
    n_cmp++; if (resp_valid !== 2'b11 || resp1_data !== 32'd5 || req_ready !== 2'b00) begin n_err++; $display("FAIL bp_both_pending: got rv %b d %0d rdy %b want 11/5/00", resp_valid, resp1_data, req_ready); end
    req_valid = 2'b01; resp_ready = 2'b01; #1;
    n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL bp_interlock: got %b want 00", req_ready); end
    @(negedge clk); #1;
    n_cmp++; if (resp_valid !== 2'b10 || req_ready !== 2'b01 || resp0_data !== 32'd3) begin n_err++; $display("FAIL bp_release: got rv %b rdy %b d %0d want 10/01/3", resp_valid, req_ready, resp0_data); end
    resp_ready = 2'b00;
    @(negedge clk); req_valid = 2'b00; #1;
    n_cmp++; if (alu_a !== 32'd100 || busy !== 1'b1) begin n_err++; $display("FAIL bp_exec0: got a %0d busy %b want 100/1", alu_a, busy); end
    @(negedge clk); #1;
    n_cmp++; if (resp_valid !== 2'b11 || resp0_data !== 32'd101 || resp1_data !== 32'd5) begin n_err++; $display("FAIL bp_final: got %b/%0d/%0d want 11/101/5", resp_valid, resp0_data, resp1_data); end
    resp_ready = 2'b11;
    @(negedge clk); #1;
    n_cmp++; if (resp_valid !== 2'b00) begin n_err++; $display("FAIL bp_drain: got %b want 00", resp_valid); end
    resp_ready = 2'b00;
  endtask

  // Last grant went to requester 0, so a tie goes to 1 under round-robin.
  task automatic test_tie_after_r0;
    logic [1:0]  exp_rdy;
    logic [31:0] exp_d;
`ifdef ALU_SHARE_STRICT_PRIO_EN
    exp_rdy = 2'b01; exp_d = 32'd2;
`else
    exp_rdy = 2'b10; exp_d = 32'd12;
`endif
    req0_op = 3'b000; req0_a = 32'd1; req0_b = 32'd1;
    req1_op = 3'b011; req1_a = 32'd8; req1_b = 32'd4;
    req_valid = 2'b11; resp_ready = 2'b11; #1;
    n_cmp++; if (req_ready !== exp_rdy) begin n_err++; $display("FAIL tie_grant: got %b want %b", req_ready, exp_rdy); end
    @(negedge clk); req_valid = 2'b00;
    @(negedge clk); #1;
    n_cmp++; if (resp_valid !== exp_rdy || (exp_rdy[1] ? resp1_data : resp0_data) !== exp_d) begin n_err++; $display("FAIL tie_resp: got %b/%0d/%0d want %b/%0d", resp_valid, resp0_data, resp1_data, exp_rdy, exp_d); end
    @(negedge clk); resp_ready = 2'b00;
  endtask

  task automatic test_reset_mid_exec;
    req_valid = 2'b10; req1_op = 3'b000; req1_a = 32'd2; req1_b = 32'd2; #1;
    n_cmp++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL mid_accept: got %b want 10", req_ready); end
    @(negedge clk); req_valid = 2'b11; #1;
    n_cmp++; if (busy !== 1'b1 || alu_a !== 32'd2) begin n_err++; $display("FAIL mid_exec: got busy %b a %0d want 1/2", busy, alu_a); end
    rst = 1'b1; #1;
    n_cmp++; if (busy !== 1'b0 || resp_valid !== 2'b00 || req_ready !== 2'b00) begin n_err++; $display("FAIL mid_rst_ctrl: got busy %b rv %b rdy %b want 0/00/00", busy, resp_valid, req_ready); end
    n_cmp++; if ({alu_a, alu_b, alu_op} !== 67'd0) begin n_err++; $display("FAIL mid_rst_alu: got %h/%h/%h want 0", alu_a, alu_b, alu_op); end
    @(negedge clk); rst = 1'b0; req_valid = 2'b00; #1;
    @(negedge clk); #1;
    n_cmp++; if (resp_valid !== 2'b00 || resp1_data !== 32'd0) begin n_err++; $display("FAIL mid_no_stale: got %b/%0d want 00/0", resp_valid, resp1_data); end
    // last returns to 1, so requester 0 wins the first tie in either build
    req0_op = 3'b000; req0_a = 32'd0; req0_b = 32'd0; req_valid = 2'b11; #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL mid_first_tie: got %b want 01", req_ready); end
    @(negedge clk); req_valid = 2'b00;
    @(negedge clk); #1;
    n_cmp++; if (resp_valid !== 2'b01 || resp0_data !== 32'd0 || resp0_zero !== 1'b1) begin n_err++; $display("FAIL mid_zero_add: got %b/%0d/%b want 01/0/1", resp_valid, resp0_data, resp0_zero); end
    resp_ready = 2'b11;
    @(negedge clk); resp_ready = 2'b00;
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_sub_shift();
    test_round_robin();
    test_backpressure();
    test_tie_after_r0();
    test_reset_mid_exec();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
